// File: rtl/video_scanlines_if.sv
// Video stream bundle between the scandoubler side (master) and the scanline stage (slave).
// Carries scan_alt only when SCANLINES_ALT_EN is defined.
interface video_scanlines_if #(
    parameter int DW = 8
);
    logic          ce_pix;
    logic [1:0]    scanlines;
`ifdef SCANLINES_ALT_EN
    logic          scan_alt;
`endif
    logic          hs_in;
    logic          vs_in;
    logic          hb_in;
    logic          vb_in;
    logic [DW-1:0] r_in;
    logic [DW-1:0] g_in;
    logic [DW-1:0] b_in;
    logic          hs_out;
    logic          vs_out;
    logic          hb_out;
    logic          vb_out;
    logic [DW-1:0] r_out;
    logic [DW-1:0] g_out;
    logic [DW-1:0] b_out;

    modport master (
`ifdef SCANLINES_ALT_EN
        output scan_alt,
`endif
        output ce_pix, scanlines, hs_in, vs_in, hb_in, vb_in, r_in, g_in, b_in,
        input  hs_out, vs_out, hb_out, vb_out, r_out, g_out, b_out
    );

    modport slave (
`ifdef SCANLINES_ALT_EN
        input  scan_alt,
`endif
        input  ce_pix, scanlines, hs_in, vs_in, hb_in, vb_in, r_in, g_in, b_in,
        output hs_out, vs_out, hb_out, vb_out, r_out, g_out, b_out
    );
endinterface

// File: rtl/video_scanlines.sv
// CRT scanline emulation: darkens every second doubled-rate line, 2 ce_pix latency on all outputs.
// Optional SCANLINES_ALT_EN swaps dark/bright line parity every frame when scan_alt=1.
module video_scanlines #(
    parameter int DW = 8
) (
    input  logic             clk_sys,
    input  logic             reset,
    video_scanlines_if.slave vid
);
    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          hb;
        logic          vb;
        logic [DW-1:0] r;
        logic [DW-1:0] g;
        logic [DW-1:0] b;
    } pix_t;

    pix_t       s1_q, s1_d;
    pix_t       out_q, out_d;
    logic       dark_q, dark_d;
    logic [1:0] mode_q, mode_d;
    logic       vs_rise, hs_rise, frame_par;
`ifdef SCANLINES_ALT_EN
    logic       par_q, par_d;
`endif

    function automatic logic [DW-1:0] dim(input logic [DW-1:0] c, input logic [1:0] m);
        case (m)
            2'd1:    dim = c - (c >> 2);
            2'd2:    dim = c >> 1;
            2'd3:    dim = c >> 2;
            default: dim = c;
        endcase
    endfunction

    always_comb begin
        // NOTE: every next-state value starts as its hold value, so no branch can infer a latch.
        s1_d   = s1_q;
        out_d  = out_q;
        dark_d = dark_q;
        mode_d = mode_q;
`ifdef SCANLINES_ALT_EN
        par_d     = par_q;
        frame_par = vid.scan_alt ? ~par_q : 1'b0;
`else
        frame_par = 1'b0;
`endif
        vs_rise = vid.vs_in & ~s1_q.vs;
        hs_rise = vid.hs_in & ~s1_q.hs;

        if (vid.ce_pix) begin
            s1_d = '{hs: vid.hs_in, vs: vid.vs_in, hb: vid.hb_in, vb: vid.vb_in,
                     r: vid.r_in, g: vid.g_in, b: vid.b_in};

            // vsync restarts the line parity and wins over a coincident hsync edge.
            if (vs_rise) begin
                mode_d = vid.scanlines;
                dark_d = frame_par;
`ifdef SCANLINES_ALT_EN
                par_d  = frame_par;
`endif
            end else if (hs_rise) begin
                dark_d = ~dark_q;
            end

            // dark_q already reflects the line that the pixel held in s1 belongs to.
            out_d = s1_q;
            if (s1_q.hb | s1_q.vb) begin
                out_d.r = '0;
                out_d.g = '0;
                out_d.b = '0;
            end else if (dark_q && (mode_q != 2'd0)) begin
                out_d.r = dim(s1_q.r, mode_q);
                out_d.g = dim(s1_q.g, mode_q);
                out_d.b = dim(s1_q.b, mode_q);
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples the same pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1_q   <= '0;
            out_q  <= '0;
            dark_q <= 1'b0;
            mode_q <= 2'd0;
`ifdef SCANLINES_ALT_EN
            par_q  <= 1'b0;
`endif
        end else begin
            s1_q   <= s1_d;
            out_q  <= out_d;
            dark_q <= dark_d;
            mode_q <= mode_d;
`ifdef SCANLINES_ALT_EN
            par_q  <= par_d;
`endif
        end
    end

    assign vid.hs_out = out_q.hs;
    assign vid.vs_out = out_q.vs;
    assign vid.hb_out = out_q.hb;
    assign vid.vb_out = out_q.vb;
    assign vid.r_out  = out_q.r;
    assign vid.g_out  = out_q.g;
    assign vid.b_out  = out_q.b;
endmodule

// File: tb/tb_video_scanlines.sv
// Self-checking bench for video_scanlines: directed scenarios plus randomized streams
// checked against a line-counting reference model.
module tb_video_scanlines;
    localparam int DW = 8;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          hb;
        logic          vb;
        logic [DW-1:0] r;
        logic [DW-1:0] g;
        logic [DW-1:0] b;
    } vid_t;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    video_scanlines_if #(.DW(DW)) vif ();

    video_scanlines #(.DW(DW)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .vid     (vif)
    );

    int total = 0;
    int bad   = 0;
    int idle  = 1;

    // Reference model: line number since last vsync plus frame parity.
    bit   m_prev_hs, m_prev_vs, m_par;
    int   m_line, m_mode;
    vid_t pend, exp_out;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vid_t dut_out();
        return vid_t'({vif.hs_out, vif.vs_out, vif.hb_out, vif.vb_out,
                       vif.r_out, vif.g_out, vif.b_out});
    endfunction

    function automatic logic [DW-1:0] shade(input logic [DW-1:0] c, input int mode);
        int v;
        v = int'(c);
        case (mode)
            1:       v = v - v / 4;
            2:       v = v / 2;
            3:       v = v / 4;
            default: v = v;
        endcase
        return DW'(v);
    endfunction

    task automatic model_sample(input vid_t p, output vid_t e);
        bit alt;
        bit dark;
        alt = 1'b0;
`ifdef SCANLINES_ALT_EN
        alt = vif.scan_alt;
`endif
        if (p.vs && !m_prev_vs) begin
            m_mode = int'(vif.scanlines);
            m_par  = alt ? !m_par : 1'b0;
            m_line = 0;
        end else if (p.hs && !m_prev_hs) begin
            m_line++;
        end
        m_prev_hs = p.hs;
        m_prev_vs = p.vs;
        dark = ((m_line % 2) == 1) != m_par;
        e = p;
        if (p.hb || p.vb) begin
            e.r = '0; e.g = '0; e.b = '0;
        end else if (dark && m_mode != 0) begin
            e.r = shade(p.r, m_mode);
            e.g = shade(p.g, m_mode);
            e.b = shade(p.b, m_mode);
        end
    endtask

    task automatic model_reset();
        m_prev_hs = 0; m_prev_vs = 0; m_par = 0;
        m_line = 0; m_mode = 0;
        pend = '0; exp_out = '0;
    endtask

    task automatic do_reset();
        vif.ce_pix = 1'b0;
        reset = 1'b1;
        @(posedge clk_sys); #1;
        check("reset_out", 64'(dut_out()), 64'(0));
        reset = 1'b0;
        model_reset();
    endtask

    // One pixel on a ce_pix cycle followed by `idle` hold cycles.
    task automatic pix(input vid_t p);
        vif.hs_in = p.hs; vif.vs_in = p.vs; vif.hb_in = p.hb; vif.vb_in = p.vb;
        vif.r_in  = p.r;  vif.g_in  = p.g;  vif.b_in  = p.b;
        vif.ce_pix = 1'b1;
        exp_out = pend;
        model_sample(p, pend);
        @(posedge clk_sys); #1;
        check("pix", 64'(dut_out()), 64'(exp_out));
        vif.ce_pix = 1'b0;
        for (int i = 0; i < idle; i++) begin
            @(posedge clk_sys); #1;
            check("hold", 64'(dut_out()), 64'(exp_out));
        end
    endtask

    task automatic line(input bit hs_first, input logic [DW-1:0] c, input int n);
        for (int i = 0; i < n; i++)
            pix('{hs: hs_first && (i == 0), vs: 1'b0, hb: 1'b0, vb: 1'b0, r: c, g: c, b: c});
    endtask

    task automatic vsync(input logic [DW-1:0] c);
        for (int i = 0; i < 2; i++)
            pix('{hs: 1'b0, vs: 1'b1, hb: 1'b0, vb: 1'b0, r: c, g: c, b: c});
    endtask

    task automatic check_rgb(input string tag, input logic [DW-1:0] c);
        check(tag, 64'({vif.r_out, vif.g_out, vif.b_out}), 64'({c, c, c}));
    endtask

    initial begin
        vid_t p;
        bit   hs_d, vs_d;
        vif.ce_pix = 0; vif.scanlines = 2'd0;
        vif.hs_in = 0; vif.vs_in = 0; vif.hb_in = 0; vif.vb_in = 0;
        vif.r_in = '0; vif.g_in = '0; vif.b_in = '0;
`ifdef SCANLINES_ALT_EN
        vif.scan_alt = 1'b0;
`endif
        repeat (2) @(posedge clk_sys);
        #1;
        do_reset();

        // Passthrough: counting colour, periodic syncs, mode off.
        for (int i = 0; i < 256; i++) begin
            p = '{hs: (i % 32) == 0, vs: i < 2, hb: 1'b0, vb: 1'b0,
                  r: DW'(i), g: DW'(255 - i), b: DW'(i)};
            pix(p);
        end
        check("pass_lat", 64'(vif.r_out), 64'(8'hFE));

        // 50% mode over four lines.
        vif.scanlines = 2'd2;
        vsync(8'hFF); line(0, 8'hFF, 6); check_rgb("m2_l0", 8'hFF);
        line(1, 8'hFF, 6); check_rgb("m2_l1", 8'h7F);
        line(1, 8'hFF, 6); check_rgb("m2_l2", 8'hFF);
        line(1, 8'hFF, 6); check_rgb("m2_l3", 8'h7F);

        // 25% mode.
        vif.scanlines = 2'd1;
        vsync(8'hFF); line(0, 8'hFF, 6);
        line(1, 8'hFF, 6); check_rgb("m1_ff", 8'hC0);
        line(1, 8'h80, 6);
        line(1, 8'h80, 6); check_rgb("m1_80", 8'h60);

        // 75% mode.
        vif.scanlines = 2'd3;
        vsync(8'hFF); line(0, 8'hFF, 6);
        line(1, 8'hFF, 6); check_rgb("m3_ff", 8'h3F);
        line(1, 8'h80, 6);
        line(1, 8'h80, 6); check_rgb("m3_80", 8'h20);

        // Mode change mid-frame only takes effect at the next vsync.
        vif.scanlines = 2'd2;
        vsync(8'hFF); line(0, 8'hFF, 6); line(1, 8'hFF, 6);
        vif.scanlines = 2'd0;
        line(1, 8'hFF, 6);
        line(1, 8'hFF, 6); check_rgb("latch_old", 8'h7F);
        vsync(8'hFF); line(0, 8'hFF, 6);
        line(1, 8'hFF, 6); check_rgb("latch_new", 8'hFF);

        // hs and vs rising together: no extra toggle.
        vif.scanlines = 2'd2;
        vsync(8'hFF); line(0, 8'hFF, 6); line(1, 8'hFF, 6);
        pix('{hs: 1'b1, vs: 1'b1, hb: 1'b0, vb: 1'b0, r: 8'hFF, g: 8'hFF, b: 8'hFF});
        line(0, 8'hFF, 6); check_rgb("hsvs_l0", 8'hFF);
        line(1, 8'hFF, 6); check_rgb("hsvs_l1", 8'h7F);

        // Blanking forces black.
        for (int i = 0; i < 3; i++)
            pix('{hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b0, r: 8'hFF, g: 8'hFF, b: 8'hFF});
        check_rgb("hblank", 8'h00);
        check("hb_out", 64'(vif.hb_out), 64'(1));

        // Reset mid-line, then first line after vsync is bright.
        vsync(8'hFF); line(0, 8'hFF, 6); line(1, 8'hFF, 3);
        do_reset();
        vsync(8'hFF); line(0, 8'hFF, 6); check_rgb("rst_l0", 8'hFF);
        line(1, 8'hFF, 6); check_rgb("rst_l1", 8'h7F);

`ifdef SCANLINES_ALT_EN
        do_reset();
        vif.scanlines = 2'd2;
        vif.scan_alt = 1'b1;
        vsync(8'hFF); line(0, 8'hFF, 6); check_rgb("alt_a_l0", 8'h7F);
        line(1, 8'hFF, 6); check_rgb("alt_a_l1", 8'hFF);
        vsync(8'hFF); line(0, 8'hFF, 6); check_rgb("alt_b_l0", 8'hFF);
        line(1, 8'hFF, 6); check_rgb("alt_b_l1", 8'h7F);
        vif.scan_alt = 1'b0;
        for (int f = 0; f < 2; f++) begin
            vsync(8'hFF); line(0, 8'hFF, 6); check_rgb("alt_off_l0", 8'hFF);
            line(1, 8'hFF, 6); check_rgb("alt_off_l1", 8'h7F);
        end
`endif

        // Randomized stream with occasional resets and mode changes.
        hs_d = 0; vs_d = 0;
        for (int i = 0; i < 2500; i++) begin
            idle = 1 + int'($urandom_range(0, 2));
            if ($urandom_range(0, 99) == 0) vif.scanlines = 2'($urandom_range(0, 3));
`ifdef SCANLINES_ALT_EN
            if ($urandom_range(0, 49) == 0) vif.scan_alt = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 399) == 0) do_reset();
            hs_d = ($urandom_range(0, 11) == 0) || (hs_d && $urandom_range(0, 1) == 1);
            vs_d = ($urandom_range(0, 59) == 0) || (vs_d && $urandom_range(0, 1) == 1);
            p = '{hs: hs_d, vs: vs_d,
                  hb: $urandom_range(0, 7) == 0, vb: $urandom_range(0, 15) == 0,
                  r: DW'($urandom), g: DW'($urandom), b: DW'($urandom)};
            pix(p);
        end
        idle = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
